// File: rtl/tile_match_engine.sv
// tile_match_engine: turns synchronized switch flips into tile flips, compares
// pairs, holds each pair visible for SHOW_CYCLES, tracks matches and moves.
module tile_match_engine #(
  parameter int NUM_TILES = 10,
  parameter int SYM_W = 3,
  parameter logic [NUM_TILES*SYM_W-1:0] TILE_SYMBOLS =
    {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int SCORE_W = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [NUM_TILES-1:0] sw,
  output logic [NUM_TILES-1:0] tile_up,
  output logic [NUM_TILES-1:0] tile_matched,
  output logic [1:0]           switches_on,
  output logic                 pair_valid,
  output logic                 pair_match,
  output logic                 all_matched,
  output logic [SCORE_W-1:0]   move_count,
  output logic                 busy
);
  localparam int IDX_W = $clog2(NUM_TILES);
  localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [NUM_TILES-1:0] LSB = NUM_TILES'(1);

  typedef enum logic [2:0] {IDLE, ONE, CMP, SHOW, RESOLVE, DONE} stateT;

  stateT state, stateNext;
  logic [NUM_TILES-1:0] syncA, syncB, syncPrev, edges;
  logic [NUM_TILES-1:0] cand, hitMask, pairMask, tileUpNext, matchedNext;
  logic [IDX_W-1:0] idxA, idxB, idxANext, idxBNext, hitIdx;
  logic [CNT_W-1:0] showCnt, showCntNext;
  logic [SCORE_W-1:0] moveNext;
  logic [SYM_W-1:0] syms [NUM_TILES];
  logic [1:0] upCount;
  logic hit, pairValidNext, pairMatchNext, allMatchedNext;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      syncA <= '0;
      syncB <= '0;
      syncPrev <= '0;
      edges <= '0;
    end else begin
      syncA <= sw;
      syncB <= syncA;
      syncPrev <= syncB;
      edges <= syncB & ~syncPrev;
    end
  end

  // Only the lowest-index acceptable request wins; others in the same cycle are lost.
  always_comb begin
    cand = edges & ~tile_up & ~tile_matched;
    hit = 1'b0;
    hitIdx = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TILES; i++) syms[i] = TILE_SYMBOLS[i*SYM_W +: SYM_W];
  end

  assign hitMask = LSB << hitIdx;
  assign pairMask = (LSB << idxA) | (LSB << idxB);
  assign busy = state == SHOW;

  always_comb begin
    stateNext = state;
    idxANext = idxA;
    idxBNext = idxB;
    showCntNext = showCnt;
    tileUpNext = tile_up;
    matchedNext = tile_matched;
    moveNext = move_count;
    pairValidNext = 1'b0;
    pairMatchNext = pair_match;
    allMatchedNext = all_matched;
    if (start) begin
      stateNext = IDLE;
      tileUpNext = '0;
      matchedNext = '0;
      moveNext = '0;
      pairMatchNext = 1'b0;
      allMatchedNext = 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          tileUpNext = tile_up | hitMask;
          idxANext = hitIdx;
          stateNext = ONE;
        end
        ONE: if (hit) begin
          tileUpNext = tile_up | hitMask;
          idxBNext = hitIdx;
          stateNext = CMP;
        end
        CMP: begin
          pairValidNext = 1'b1;
          pairMatchNext = syms[idxA] == syms[idxB];
          moveNext = &move_count ? move_count : move_count + 1'b1;
          showCntNext = CNT_W'(SHOW_CYCLES - 1);
          stateNext = SHOW;
        end
        SHOW: begin
          stateNext = showCnt == '0 ? RESOLVE : SHOW;
          showCntNext = showCnt == '0 ? showCnt : showCnt - 1'b1;
        end
        RESOLVE: begin
          tileUpNext = tile_up & ~pairMask;
          matchedNext = tile_matched | (pair_match ? pairMask : '0);
          allMatchedNext = &matchedNext;
          stateNext = &matchedNext ? DONE : IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    upCount = '0;
    for (int i = 0; i < NUM_TILES; i++) upCount = upCount + {1'b0, tileUpNext[i]};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      idxA <= '0;
      idxB <= '0;
      showCnt <= '0;
      tile_up <= '0;
      tile_matched <= '0;
      switches_on <= '0;
      move_count <= '0;
      pair_valid <= 1'b0;
      pair_match <= 1'b0;
      all_matched <= 1'b0;
    end else begin
      state <= stateNext;
      idxA <= idxANext;
      idxB <= idxBNext;
      showCnt <= showCntNext;
      tile_up <= tileUpNext;
      tile_matched <= matchedNext;
      switches_on <= upCount;
      move_count <= moveNext;
      pair_valid <= pairValidNext;
      pair_match <= pairMatchNext;
      all_matched <= allMatchedNext;
    end
  end
endmodule

// File: tb/tb_tile_match_engine.sv
// tb_tile_match_engine: directed scenarios with hand-computed expectations,
// SHOW_CYCLES=4 and default symbols (tile i pairs with tile i+5).
module tb_tile_match_engine;
  logic CLOCK_50, resetn, start;
  logic [9:0] sw, tile_up, tile_matched;
  logic [1:0] switches_on;
  logic pair_valid, pair_match, all_matched, busy;
  logic [7:0] move_count;
  logic [33:0] allOut;
  int checks = 0;
  int failures = 0;

  tile_match_engine #(.SHOW_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .sw(sw),
    .tile_up(tile_up), .tile_matched(tile_matched), .switches_on(switches_on),
    .pair_valid(pair_valid), .pair_match(pair_match), .all_matched(all_matched),
    .move_count(move_count), .busy(busy)
  );

  assign allOut = {tile_up, tile_matched, switches_on, pair_valid, pair_match,
                   all_matched, move_count, busy};

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_pair(input int a, input int b);
    sw[a] = 1'b1;
    cyc(4);
    sw[b] = 1'b1;
    cyc(4);
    sw[a] = 1'b0;
    sw[b] = 1'b0;
    cyc(6);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    sw = '0;
    cyc(3);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++; if (allOut !== 34'h0) begin failures++; $display("FAIL reset_idle cycle=%0d got=%h exp=0", i, allOut); end
    end
  endtask

  task automatic test_match;
    int pv = 0;
    int bz = 0;
    sw[0] = 1'b1;
    cyc(3);
    checks++; if (tile_up !== 10'h000) begin failures++; $display("FAIL latency_early got=%h exp=000", tile_up); end
    cyc(1);
    checks++; if (tile_up !== 10'h001) begin failures++; $display("FAIL latency_up got=%h exp=001", tile_up); end
    checks++; if (switches_on !== 2'd1) begin failures++; $display("FAIL swon_one got=%0d exp=1", switches_on); end
    sw[5] = 1'b1;
    cyc(4);
    checks++; if (tile_up !== 10'h021) begin failures++; $display("FAIL match_up got=%h exp=021", tile_up); end
    checks++; if (switches_on !== 2'd2) begin failures++; $display("FAIL swon_two got=%0d exp=2", switches_on); end
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      pv += int'(pair_valid);
      bz += int'(busy);
      if (i == 0) begin
        checks++; if (pair_match !== 1'b1) begin failures++; $display("FAIL match_result got=%b exp=1", pair_match); end
        checks++; if (move_count !== 8'd1) begin failures++; $display("FAIL match_moves got=%0d exp=1", move_count); end
      end
    end
    checks++; if (pv !== 1) begin failures++; $display("FAIL match_pv_count got=%0d exp=1", pv); end
    checks++; if (bz !== 4) begin failures++; $display("FAIL match_busy_cycles got=%0d exp=4", bz); end
    checks++; if (tile_up !== 10'h000) begin failures++; $display("FAIL match_cleared got=%h exp=000", tile_up); end
    checks++; if (tile_matched !== 10'h021) begin failures++; $display("FAIL match_matched got=%h exp=021", tile_matched); end
    checks++; if (switches_on !== 2'd0) begin failures++; $display("FAIL match_swon got=%0d exp=0", switches_on); end
    sw = '0;
    cyc(3);
  endtask

  task automatic test_mismatch;
    sw[1] = 1'b1;
    cyc(4);
    sw[2] = 1'b1;
    cyc(4);
    checks++; if (tile_up !== 10'h006) begin failures++; $display("FAIL mis_up got=%h exp=006", tile_up); end
    cyc(1);
    checks++; if ({pair_valid, pair_match} !== 2'b10) begin failures++; $display("FAIL mis_result got=%b exp=10", {pair_valid, pair_match}); end
    checks++; if (move_count !== 8'd2) begin failures++; $display("FAIL mis_moves got=%0d exp=2", move_count); end
    sw = '0;
    cyc(5);
    checks++; if (tile_up !== 10'h000) begin failures++; $display("FAIL mis_cleared got=%h exp=000", tile_up); end
    checks++; if (tile_matched !== 10'h021) begin failures++; $display("FAIL mis_matched got=%h exp=021", tile_matched); end
    checks++; if ({pair_valid, pair_match} !== 2'b00) begin failures++; $display("FAIL mis_held got=%b exp=00", {pair_valid, pair_match}); end
  endtask

  task automatic test_simultaneous;
    sw[3] = 1'b1;
    sw[7] = 1'b1;
    cyc(4);
    checks++; if (tile_up !== 10'h008) begin failures++; $display("FAIL simul_up got=%h exp=008", tile_up); end
    checks++; if (switches_on !== 2'd1) begin failures++; $display("FAIL simul_swon got=%0d exp=1", switches_on); end
    sw[0] = 1'b1;
    cyc(4);
    checks++; if (tile_up !== 10'h008) begin failures++; $display("FAIL matched_ignored got=%h exp=008", tile_up); end
    sw[0] = 1'b0;
    sw[8] = 1'b1;
    cyc(4);
    checks++; if (tile_up !== 10'h108) begin failures++; $display("FAIL simul_pair got=%h exp=108", tile_up); end
    sw[4] = 1'b1;
    cyc(1);
    checks++; if ({busy, pair_match} !== 2'b11) begin failures++; $display("FAIL show_busy got=%b exp=11", {busy, pair_match}); end
    cyc(5);
    checks++; if (tile_up !== 10'h000) begin failures++; $display("FAIL show_ignored got=%h exp=000", tile_up); end
    checks++; if (tile_matched !== 10'h129) begin failures++; $display("FAIL simul_matched got=%h exp=129", tile_matched); end
    checks++; if (move_count !== 8'd3) begin failures++; $display("FAIL simul_moves got=%0d exp=3", move_count); end
    sw = '0;
    cyc(3);
  endtask

  task automatic test_all_matched;
    do_pair(1, 6);
    do_pair(2, 7);
    checks++; if (all_matched !== 1'b0) begin failures++; $display("FAIL early_all got=%b exp=0", all_matched); end
    do_pair(4, 9);
    checks++; if (all_matched !== 1'b1) begin failures++; $display("FAIL all_flag got=%b exp=1", all_matched); end
    checks++; if (tile_matched !== 10'h3FF) begin failures++; $display("FAIL all_tiles got=%h exp=3ff", tile_matched); end
    checks++; if (move_count !== 8'd6) begin failures++; $display("FAIL all_moves got=%0d exp=6", move_count); end
    sw[0] = 1'b1;
    cyc(4);
    checks++; if ({tile_up, move_count} !== {10'h000, 8'd6}) begin failures++; $display("FAIL done_ignored got=%h exp=%h", {tile_up, move_count}, {10'h000, 8'd6}); end
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    checks++; if (allOut !== 34'h0) begin failures++; $display("FAIL start_clear got=%h exp=0", allOut); end
    cyc(4);
    checks++; if (tile_up !== 10'h000) begin failures++; $display("FAIL start_no_reflip got=%h exp=000", tile_up); end
    sw[0] = 1'b0;
    cyc(3);
    sw[0] = 1'b1;
    cyc(4);
    checks++; if (tile_up !== 10'h001) begin failures++; $display("FAIL start_idle got=%h exp=001", tile_up); end
    sw[0] = 1'b0;
    cyc(3);
  endtask

  task automatic test_saturation;
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    cyc(1);
    checks++; if (allOut !== 34'h0) begin failures++; $display("FAIL sat_reset got=%h exp=0", allOut); end
    for (int i = 1; i <= 300; i++) begin
      do_pair(1, 2);
      if (i == 254) begin
        checks++; if (move_count !== 8'hFE) begin failures++; $display("FAIL sat_254 got=%h exp=fe", move_count); end
      end
    end
    checks++; if (move_count !== 8'hFF) begin failures++; $display("FAIL sat_ff got=%h exp=ff", move_count); end
    checks++; if ({tile_matched, pair_match} !== 11'h0) begin failures++; $display("FAIL sat_nomatch got=%h exp=0", {tile_matched, pair_match}); end
  endtask

  task automatic test_reset_mid_show;
    sw[0] = 1'b1;
    cyc(4);
    sw[5] = 1'b1;
    cyc(6);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    resetn = 1'b0;
    #1;
    checks++; if (allOut !== 34'h0) begin failures++; $display("FAIL mid_reset got=%h exp=0", allOut); end
    sw = '0;
    cyc(2);
    resetn = 1'b1;
    cyc(2);
    checks++; if (allOut !== 34'h0) begin failures++; $display("FAIL mid_release got=%h exp=0", allOut); end
  endtask

  initial begin
    test_reset;
    test_match;
    test_mismatch;
    test_simultaneous;
    test_all_matched;
    test_saturation;
    test_reset_mid_show;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
